// File: rtl/hex_pkg.sv
// Shared types and constants for the hex page scheduler: FSM states, source
// indices, active-low 7-segment patterns (bit order g..a) and a round-robin picker.
package hex_pkg;

  typedef enum logic [1:0] {IDLE, SWITCH, SHOW} state_t;

  localparam int NUM_SRC = 3;
  localparam int NUM_DIG = 8;
  localparam int SEG_W   = 7;

  localparam logic [1:0] SRC_STATUS = 2'd0;
  localparam logic [1:0] SRC_SLICE  = 2'd1;
  localparam logic [1:0] SRC_DEBUG  = 2'd2;
  localparam logic [1:0] SRC_NONE   = 2'd3;

  localparam logic [SEG_W-1:0] SEG_DARK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

  // First set request at or after 'start', wrapping modulo three.
  function automatic logic [1:0] rr_pick(input logic [NUM_SRC-1:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = SRC_NONE;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = 2'((int'(start) + k) % NUM_SRC);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// 4-bit glyph code to active-low 7-segment pattern; blank forces the digit dark.
module seg7_glyph
  import hex_pkg::*;
(
  input  logic [3:0]       code,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_DARK;
    if (!blank) begin
      case (code)
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        4'hF: seg = SEG_F;
        default: seg = SEG_DARK;
      endcase
    end
  end

endmodule

// File: rtl/hex_page_scheduler.sv
// Arbitrates three page sources onto eight 7-segment digits with dwell-based rotation
// and status preemption. Define HEX_DEBUG_PAGE_EN to let the debug source (2) take part.
module hex_page_scheduler
  import hex_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   req_i,
  input  logic [95:0]          page_data_i,
  input  logic [23:0]          page_blank_i,
  input  logic                 hold_i,
  output logic [NUM_SRC-1:0]   ack_o,
  output logic [1:0]           active_page_o,
  output logic [SEG_W-1:0]     HEX0_o,
  output logic [SEG_W-1:0]     HEX1_o,
  output logic [SEG_W-1:0]     HEX2_o,
  output logic [SEG_W-1:0]     HEX3_o,
  output logic [SEG_W-1:0]     HEX4_o,
  output logic [SEG_W-1:0]     HEX5_o,
  output logic [SEG_W-1:0]     HEX6_o,
  output logic [SEG_W-1:0]     HEX7_o
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_SAT = CW'(DWELL_CYCLES - 1);
`ifdef HEX_DEBUG_PAGE_EN
  localparam logic [NUM_SRC-1:0] SRC_MASK = 3'b111;
`else
  localparam logic [NUM_SRC-1:0] SRC_MASK = 3'b011;
`endif

  state_t                          state_q, state_d;
  logic [1:0]                      cur_q, nxt_src, rr_src;
  logic [CW-1:0]                   cnt_q;
  logic                            req0_q;
  logic [NUM_SRC-1:0]              ack_q, req_m, cur_oh;
  logic [31:0]                     page_sel;
  logic [NUM_DIG-1:0]              blank_sel;
  logic [NUM_DIG-1:0][SEG_W-1:0]   seg, hex_q;

  assign req_m  = req_i & SRC_MASK;
  assign cur_oh = 3'b001 << cur_q;  // SRC_NONE shifts out to zero
  assign rr_src = rr_pick(req_m, (cur_q >= SRC_DEBUG) ? SRC_STATUS : cur_q + 2'd1);

  // Priority in SHOW: status preemption, then loss of the granted request, then dwell rotation.
  always_comb begin
    state_d = state_q;
    nxt_src = cur_q;
    case (state_q)
      IDLE: if (|req_m) begin
        state_d = SWITCH;
        nxt_src = rr_pick(req_m, SRC_STATUS);
      end
      SWITCH: state_d = SHOW;
      SHOW: begin
        if (req_m[0] && !req0_q && cur_q != SRC_STATUS) begin
          state_d = SWITCH;
          nxt_src = SRC_STATUS;
        end else if (~|(req_m & cur_oh)) begin
          state_d = (|req_m) ? SWITCH : IDLE;
          nxt_src = rr_src;
        end else if (cnt_q == CNT_SAT && !hold_i && |(req_m & ~cur_oh)) begin
          state_d = SWITCH;
          nxt_src = rr_src;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Page follows the current grant; goes dark whenever the next state is IDLE.
  always_comb begin
    page_sel  = '0;
    blank_sel = '1;
    if (cur_q != SRC_NONE) begin
      page_sel = page_data_i[32*int'(cur_q) +: 32];
      if (state_d != IDLE) blank_sel = page_blank_i[8*int'(cur_q) +: 8];
    end
  end

  for (genvar d = 0; d < NUM_DIG; d++) begin : g_dig
    seg7_glyph u_glyph (
      .code  (page_sel[4*d +: 4]),
      .blank (blank_sel[d]),
      .seg   (seg[d])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= SRC_NONE;
      cnt_q   <= '0;
      req0_q  <= 1'b0;
      ack_q   <= '0;
      hex_q   <= {NUM_DIG{SEG_DARK}};
    end else begin
      state_q <= state_d;
      req0_q  <= req_m[0];
      ack_q   <= (state_d == SWITCH) ? (3'b001 << nxt_src) : '0;
      if (state_d == SWITCH)    cur_q <= nxt_src;
      else if (state_d == IDLE) cur_q <= SRC_NONE;
      if (state_q != SHOW)                   cnt_q <= '0;
      else if (!hold_i && cnt_q != CNT_SAT)  cnt_q <= cnt_q + CW'(1);
      hex_q <= seg;
    end
  end

  assign ack_o         = ack_q;
  assign active_page_o = cur_q;
  assign HEX0_o = hex_q[0];
  assign HEX1_o = hex_q[1];
  assign HEX2_o = hex_q[2];
  assign HEX3_o = hex_q[3];
  assign HEX4_o = hex_q[4];
  assign HEX5_o = hex_q[5];
  assign HEX6_o = hex_q[6];
  assign HEX7_o = hex_q[7];

endmodule

// File: tb/tb_hex_page_scheduler.sv
// Self-checking bench for hex_page_scheduler (DWELL_CYCLES=4): directed scenarios
// followed by random traffic, all compared against a rule-level reference model.
module tb_hex_page_scheduler;

  localparam int DWELL = 4;
`ifdef HEX_DEBUG_PAGE_EN
  localparam logic [2:0] MASK = 3'b111;
  localparam logic [2:0] PAIR = 3'b110;
  localparam int G0 = 1, G1 = 2;
`else
  localparam logic [2:0] MASK = 3'b011;
  localparam logic [2:0] PAIR = 3'b011;
  localparam int G0 = 0, G1 = 1;
`endif
  localparam logic [55:0] ALL_DARK = {8{7'h7F}};
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [95:0] pdata;
  logic [23:0] pblank;
  logic        hold;
  logic [2:0]  ack;
  logic [1:0]  act;
  logic [6:0]  h0, h1, h2, h3, h4, h5, h6, h7;
  logic [55:0] hexcat;

  assign hexcat = {h7, h6, h5, h4, h3, h2, h1, h0};

  hex_page_scheduler #(.DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst(rst), .req_i(req), .page_data_i(pdata), .page_blank_i(pblank),
    .hold_i(hold), .ack_o(ack), .active_page_o(act),
    .HEX0_o(h0), .HEX1_o(h1), .HEX2_o(h2), .HEX3_o(h3),
    .HEX4_o(h4), .HEX5_o(h5), .HEX6_o(h6), .HEX7_o(h7)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // Reference model: which source is shown, whether this is its switch-in cycle, dwell count.
  int          m_grant;
  bit          m_sw;
  int          m_dwell;
  bit          m_prev0;
  logic [2:0]  e_ack;
  logic [1:0]  e_act;
  logic [55:0] e_hex;

  function automatic logic [2:0] bit_of(input int s);
    return 3'(1 << s);
  endfunction

  function automatic int rr(input logic [2:0] r, input int start);
    for (int k = 0; k < 3; k++)
      if (r[(start + k) % 3]) return (start + k) % 3;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_grant = -1; m_sw = 0; m_dwell = 0; m_prev0 = 0;
    e_ack = 3'b000; e_act = 2'd3; e_hex = ALL_DARK;
  endtask

  task automatic m_step();
    logic [2:0] r;
    bit go, to_idle;
    int nx;
    r = req & MASK; go = 0; to_idle = 0; nx = 0;
    if (m_grant < 0) begin
      if (r != 0) begin go = 1; nx = rr(r, 0); end
    end else if (!m_sw) begin
      if (r[0] && !m_prev0 && m_grant != 0) begin go = 1; nx = 0; end
      else if (!r[m_grant]) begin
        if (r != 0) begin go = 1; nx = rr(r, (m_grant + 1) % 3); end
        else to_idle = 1;
      end else if (m_dwell == DWELL - 1 && !hold && (r & ~bit_of(m_grant)) != 0) begin
        go = 1; nx = rr(r, (m_grant + 1) % 3);
      end
    end
    e_hex = ALL_DARK;
    if (!to_idle && m_grant >= 0)
      for (int d = 0; d < 8; d++)
        e_hex[7*d +: 7] = pblank[8*m_grant + d] ? 7'h7F : GLYPH[pdata[32*m_grant + 4*d +: 4]];
    if (m_sw) m_dwell = 0;
    else if (m_grant >= 0 && !hold && m_dwell < DWELL - 1) m_dwell++;
    m_sw  = go;
    e_ack = go ? bit_of(nx) : 3'b000;
    if (go) begin m_grant = nx; e_act = 2'(nx); end
    else if (to_idle) begin m_grant = -1; e_act = 2'd3; end
    m_prev0 = r[0];
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) m_reset(); else m_step();
    #1;
    chk("ack", 64'(ack), 64'(e_ack));
    chk("active_page", 64'(act), 64'(e_act));
    chk("hex", 64'(hexcat), 64'(e_hex));
  endtask

  // Reset asserted mid-cycle must act before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_ack", 64'(ack), 64'(3'b000));
    chk("rst_active", 64'(act), 64'(2'd3));
    chk("rst_hex", 64'(hexcat), 64'(ALL_DARK));
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int lim, output int n);
    n = 0;
    do begin step(); n++; end while (ack == 3'b000 && n < lim);
  endtask

  initial begin
    logic [2:0] aq[$];
    int         ac[$];
    int         n, acks;

    req = 3'b000; hold = 1'b0; pblank = '0;
    pdata = {$urandom, $urandom, $urandom};
    do_reset();
    repeat (3) step();
    chk("idle_dark", 64'(hexcat), 64'(ALL_DARK));

    // single slice request with partial blanking
    pdata[63:32] = 32'h0000_0016; pblank[15:8] = 8'hFC; req = 3'b010;
    step();
    chk("r030_ack", 64'(ack), 64'(3'b010));
    step();
    chk("r030_hex1", 64'(h1), 64'(7'b1111001));
    chk("r030_hex0", 64'(h0), 64'(7'b0000010));
    chk("r030_dark", 64'({h7, h6, h5, h4, h3, h2}), 64'({6{7'h7F}}));
    chk("r030_active", 64'(act), 64'(2'd1));
    req = 3'b000; pblank = '0;
    repeat (2) step();

    // two sources held: alternating grants every SWITCH + dwell
    req = PAIR;
    for (int i = 0; i < 25; i++) begin
      step();
      if (ack != 3'b000) begin aq.push_back(ack); ac.push_back(i); end
    end
    chk("r031_count", 64'(aq.size() >= 3), 64'(1));
    if (aq.size() >= 3) begin
      chk("r031_g0", 64'(aq[0]), 64'(bit_of(G0)));
      chk("r031_g1", 64'(aq[1]), 64'(bit_of(G1)));
      chk("r031_g2", 64'(aq[2]), 64'(bit_of(G0)));
      chk("r031_gap1", 64'(ac[1] - ac[0]), 64'(5));
      chk("r031_gap2", 64'(ac[2] - ac[1]), 64'(5));
    end
    req = 3'b000;
    repeat (3) step();

    // status preemption while showing the higher source, dwell counter at 1
    req = bit_of(G1);
    repeat (3) step();
    req = bit_of(G1) | 3'b001;
    step();
    chk("r032_ack", 64'(ack), 64'(3'b001));
    chk("r032_active", 64'(act), 64'(2'd0));
    req = 3'b000;
    repeat (3) step();

    // hold freezes dwell: no rotation while held, at least 4 SHOW cycles after release
    req = PAIR;
    wait_ack(10, n);
    chk("r033_first_grant", 64'(ack), 64'(bit_of(G0)));
    hold = 1'b1; acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ack != 3'b000) acks++;
    end
    chk("r033_no_rotate", 64'(acks), 64'(0));
    hold = 1'b0;
    wait_ack(20, n);
    chk("r033_rotated", 64'(ack), 64'(bit_of(G1)));
    chk("r033_latency_min", 64'(n >= 4), 64'(1));

    // reset pulse during SHOW, released mid-cycle: first ack after the next edge
    repeat (2) step();
    do_reset();
    wait_ack(5, n);
    chk("r034_first_ack", 64'(n), 64'(1));
    chk("r034_grant", 64'(ack), 64'(bit_of(G0)));
    req = 3'b000;
    repeat (3) step();

    // debug-only request
    req = 3'b100; acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack != 3'b000) acks++;
    end
`ifdef HEX_DEBUG_PAGE_EN
    chk("r035_debug_granted", 64'(acks), 64'(1));
`else
    chk("r035_no_ack", 64'(acks), 64'(0));
    chk("r035_dark", 64'(hexcat), 64'(ALL_DARK));
    chk("r035_active", 64'(act), 64'(2'd3));
`endif
    req = 3'b000;
    repeat (2) step();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else begin
        if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
        hold = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0) pdata = {$urandom, $urandom, $urandom};
        pblank = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0;
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/hex_page_scheduler.md
HEX_PAGE_SCHEDULER -- requirements
Module: hex_page_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 50000000, minimum cycles a page is shown before rotation (1 s at 50 MHz).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_i  input  3  page request per source: bit0 status, bit1 slice count, bit2 debug.
REQ-005 SHALL have port page_data_i  input  96  eight 4-bit glyph codes per source, source s at [32s+31:32s], digit d at [4d+3:4d].
REQ-006 SHALL have port page_blank_i  input  24  per-digit blank mask per source, bit 8s+d set = digit d dark.
REQ-007 SHALL have port hold_i  input  1  level, freezes dwell counter (pause).
REQ-008 SHALL have port ack_o  output  3  one-hot, one-cycle pulse when a source is granted.
REQ-009 SHALL have port active_page_o  output  2  granted source index, 2'd3 = none.
REQ-010 SHALL have ports HEX0_o..HEX7_o  output  7 each  active-low segments, bit order g..a = [6:0].

Function
REQ-011 SHALL implement FSM IDLE, SWITCH, SHOW.
REQ-012 In IDLE with req_i == 0, SHALL stay in IDLE with all HEX outputs 7'b1111111.
REQ-013 In IDLE with req_i != 0, SHALL choose the lowest set bit and enter SWITCH next cycle.
REQ-014 In SWITCH (exactly one cycle), SHALL register the grant, pulse ack_o, clear the dwell counter and enter SHOW.
REQ-015 In SHOW, HEX outputs SHALL reflect the granted source's live page_data_i/page_blank_i with one-cycle registered latency.
REQ-016 Glyph encoding SHALL be 0-9 digits; A,b,C,d,E,F for 10-15; blank mask overrides glyph.
REQ-017 Dwell counter SHALL increment each SHOW cycle unless hold_i=1 and SHALL saturate at DWELL_CYCLES-1.
REQ-018 Rotation SHALL occur when the counter is saturated and another source requests; next grant is round-robin from (current+1) mod 3 over set req_i bits.
REQ-019 Status preemption: req_i[0] rising while a non-status source is granted SHALL force SWITCH to source 0 next cycle, ignoring dwell and hold_i.
REQ-020 If the granted source drops its req, SHALL go to SWITCH (next round-robin source) if any req set, else to IDLE.
REQ-021 Saturated counter with only the granted source requesting SHALL keep SHOW, with no ack pulse.
REQ-022 Latency: decision cycle N, ack_o high in N+1, new page on HEX outputs at N+2.
REQ-023 active_page_o SHALL update in the SWITCH cycle and read 2'd3 in IDLE.

Reset
REQ-024 rst asserted SHALL immediately force IDLE, counter 0, ack_o 0, active_page_o 2'd3 and all HEX outputs 7'b1111111.
REQ-025 Reset mid-SHOW or mid-SWITCH SHALL discard the grant; after release, arbitration restarts from IDLE on the first clock edge.

Configuration
REQ-026 Macro HEX_DEBUG_PAGE_EN defined: source 2 SHALL participate as specified.
REQ-027 HEX_DEBUG_PAGE_EN undefined: req_i[2] SHALL be ignored, ack_o[2] held 0, rotation over sources 0-1 only.

Structure
REQ-028 Shared package hex_pkg SHALL hold the state enum, source index constants (SRC_STATUS, SRC_SLICE, SRC_DEBUG, SRC_NONE) and the 7-bit segment constants (DARK, digits 0-9, A-F).
REQ-029 The glyph-to-segment lookup SHALL be a sub-module seg7_glyph (4-bit code + blank in, 7-bit active-low out), instantiated eight times.

Verification (DWELL_CYCLES=4)
REQ-030 req_i=3'b010 from IDLE, slice page 32'h0000_0016 with blank 8'hFC -> ack_o[1] at cycle 2, HEX1_o=7'b1111001, HEX0_o=7'b0000010, HEX2..7 dark at cycle 3.
REQ-031 req_i=3'b110 held -> grants alternate 1,2,1 with ack pulses exactly 5 cycles apart (SWITCH + 4 dwell).
REQ-032 Showing source 2, assert req_i[0] at counter 1 -> ack_o=3'b001 next cycle, active_page_o=0, dwell ignored.
REQ-033 hold_i=1 for 10 cycles while req_i=3'b110 -> no rotation during hold; rotation 4 SHOW cycles after release at the earliest.
REQ-034 rst pulsed for 1 cycle during SHOW -> all HEX outputs 7'b1111111 and active_page_o=3 in the same cycle; first ack 2 cycles after release.
REQ-035 Build without HEX_DEBUG_PAGE_EN, req_i=3'b100 -> stays IDLE, all HEX outputs dark, ack_o never set.
